// File: rtl/mic_pkg.sv
// mic_pkg: shared definitions for the microphone receive path.
//   MIC_DATA_W / MIC_SLOT_W : default sample width and SCK periods per WS half-frame
//   mic_state_e             : receiver framing state (SYNC, SHIFT)
//   CH_LEFT / CH_RIGHT      : WS level of each channel
//   SYNC_SCK/SYNC_WS/SYNC_SD: bit positions of the pins in the synchroniser vector
package mic_pkg;

  localparam int MIC_DATA_W = 24;
  localparam int MIC_SLOT_W = 32;

  typedef enum logic {
    SYNC  = 1'b0,
    SHIFT = 1'b1
  } mic_state_e;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  localparam int SYNC_SCK = 2;
  localparam int SYNC_WS  = 1;
  localparam int SYNC_SD  = 0;

endpackage

// File: rtl/mic_in_sync.sv
// mic_in_sync: 2-FF synchroniser for a small vector of asynchronous pins,
// with a third stage on one selected bit to detect its rising edge.
//   clk, rst  : system clock, asynchronous active-high reset
//   async_in  : raw pins
//   sync_out  : pins after two flops (s2)
//   sck_rise  : one-cycle strobe, s2 & ~s3 on bit EDGE_BIT
module mic_in_sync #(
  parameter int W        = 3,
  parameter int EDGE_BIT = W - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync_out,
  output logic         sck_rise
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic         s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2[EDGE_BIT];
    end
  end

  assign sync_out = s2;
  assign sck_rise = s2[EDGE_BIT] & ~s3;

endmodule

// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx: I2S receiver for the microphone array, clocked entirely by clk.
// mic_sck/mic_ws/mic_sd are oversampled as asynchronous pins; each slot is
// deserialised MSB-first with the I2S one-bit delay after a WS edge.
//   clk, rst        : system clock, asynchronous active-high reset
//   en              : receive enable; low forces SYNC and drops a partial word
//   mic_sck/ws/sd   : I2S pins (asynchronous)
//   sample_data/ch  : held sample and its channel (WS level during the slot)
//   sample_valid    : holding register full
//   sample_ready    : downstream accept
//   overrun         : pulse, completed word dropped because holding register full
//   frame_err       : pulse, slot shorter than DATA_W bits or longer than SLOT_W
//   dbg_state       : current framing state
//
// Handshake: a word transfers on any clk edge where sample_valid && sample_ready.
// While sample_valid is high, sample_data/sample_ch do not change until that
// transfer; valid never drops without a transfer (except on reset).
module i2s_mic_rx
  import mic_pkg::*;
#(
  parameter int DATA_W = MIC_DATA_W,
  parameter int SLOT_W = MIC_SLOT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mic_sck,
  input  logic              mic_ws,
  input  logic              mic_sd,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_ch,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              frame_err,
  output mic_state_e        dbg_state
);

  localparam logic [7:0] DATA_IDX = 8'(DATA_W);
  localparam logic [7:0] LAST_IDX = 8'(DATA_W - 1);
  localparam logic [7:0] SLOT_IDX = 8'(SLOT_W);

  // ---------------------------------------------------------------- input sync
  logic [2:0] sync_vec;
  logic       sck_rise;
  logic       rise;
  logic       ws_s;
  logic       sd_s;

  mic_in_sync #(
    .W        (3),
    .EDGE_BIT (SYNC_SCK)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in ({mic_sck, mic_ws, mic_sd}),
    .sync_out (sync_vec),
    .sck_rise (sck_rise)
  );

  // sck_rise already implies the synchronised level is high; qualifying it
  // with that level keeps the strobe tied to the same sampled vector as ws/sd.
  assign rise = sck_rise & sync_vec[SYNC_SCK];
  assign ws_s = sync_vec[SYNC_WS];
  assign sd_s = sync_vec[SYNC_SD];

  // ---------------------------------------------------------------- framing FSM
  mic_state_e        state,     state_n;
  logic [7:0]        bit_idx,   bit_idx_n;
  logic              slot_ch,   slot_ch_n;
  logic [DATA_W-1:0] shreg,     shreg_n;
  logic              ws_prev,   ws_prev_n;
  logic              frame_err_n;
  logic              word_done, word_done_n;
  logic              ws_chg;
  logic [DATA_W-1:0] shifted;

  assign ws_chg  = ws_s ^ ws_prev;
  assign shifted = {shreg[DATA_W-2:0], sd_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SYNC;
      bit_idx   <= '0;
      slot_ch   <= CH_LEFT;
      shreg     <= '0;
      ws_prev   <= 1'b0;
      frame_err <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      bit_idx   <= bit_idx_n;
      slot_ch   <= slot_ch_n;
      shreg     <= shreg_n;
      ws_prev   <= ws_prev_n;
      frame_err <= frame_err_n;
      word_done <= word_done_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_idx_n   = bit_idx;
    slot_ch_n   = slot_ch;
    shreg_n     = shreg;
    ws_prev_n   = ws_prev;
    frame_err_n = 1'b0;
    word_done_n = 1'b0;

    // WS history is tracked even while disabled so re-enabling waits for a
    // genuine WS edge rather than treating the current level as one.
    if (rise) ws_prev_n = ws_s;

    if (!en) begin
      state_n   = SYNC;
      bit_idx_n = '0;
      if (rise) shreg_n = shifted;
    end else if (rise) begin
      unique case (state)
        SYNC: begin
          shreg_n = shifted;
          if (ws_chg) begin
            // The rise that shows the WS edge carries no data bit.
            bit_idx_n = '0;
            slot_ch_n = ws_s;
            state_n   = SHIFT;
          end
        end
        SHIFT: begin
          if (ws_chg) begin
            if (bit_idx < DATA_IDX) frame_err_n = 1'b1;
            bit_idx_n = '0;
            slot_ch_n = ws_s;
          end else if (bit_idx < DATA_IDX) begin
            shreg_n   = shifted;
            bit_idx_n = bit_idx + 8'd1;
            if (bit_idx == LAST_IDX) word_done_n = 1'b1;
          end else if (bit_idx >= SLOT_IDX) begin
            // One more bit would run past the slot: WS edge went missing.
            frame_err_n = 1'b1;
            state_n     = SYNC;
          end else begin
            bit_idx_n = bit_idx + 8'd1;
          end
        end
        default: state_n = SYNC;
      endcase
    end
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------- word stage
  // Copies the finished word out of the shift register before the next SCK
  // rise can disturb it, and sets the fixed pin-to-valid latency.
  logic              pend_valid;
  logic [DATA_W-1:0] pend_data;
  logic              pend_ch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_ch    <= CH_LEFT;
    end else begin
      pend_valid <= word_done;
      if (word_done) begin
        pend_data <= shreg;
        pend_ch   <= slot_ch;
      end
    end
  end

  // ---------------------------------------------------------------- holding reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_data  <= '0;
      sample_ch    <= CH_LEFT;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (pend_valid) begin
        if (!sample_valid || sample_ready) begin
          sample_data  <= pend_data;
          sample_ch    <= pend_ch;
          sample_valid <= 1'b1;
        end else begin
          // Keep the unaccepted word stable; the newer one is lost.
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule
